dec_scan_seq: RTL

DEC_SCAN_SEQ -- requirements
Module: dec_scan_seq

---
 rtl/dec_scan_pkg.sv | 10 +
 rtl/dec4to16.sv | 10 +
 rtl/dec_scan_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/dec_scan_pkg.sv
// Shared widths and FSM state type for the decoded address scan sequencer.
package dec_scan_pkg;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SEL_W  = 1 << ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/dec4to16.sv
// Combinational binary-to-one-hot decoder for the scan address.
module dec4to16 #(
  parameter int unsigned ADDR_W = dec_scan_pkg::ADDR_W,
  parameter int unsigned SEL_W  = dec_scan_pkg::SEL_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SEL_W-1:0]  sel_c
);
  assign sel_c = SEL_W'(1) << addr_i;
endmodule

// File: rtl/dec_scan_seq.sv
// Walks a run of cmd_len+1 addresses up or down from cmd_start, presenting
// each as a registered one-hot select beat on a valid/ready stream.
module dec_scan_seq import dec_scan_pkg::*; #(
  parameter int unsigned ADDR_W = dec_scan_pkg::ADDR_W,
  parameter int unsigned SEL_W  = dec_scan_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              cmd_down,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_sel,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              down_q, down_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  dec_sel_c;
  logic              accept_c;
  logic              xfer_c;

  // cmd_ready_q is low for the first cycle after reset, so it gates acceptance.
  assign accept_c = cmd_valid && cmd_ready_q;
  assign xfer_c   = valid_q && out_ready;

  // Decode the next address so the select register updates with it.
  dec4to16 #(
    .ADDR_W(ADDR_W),
    .SEL_W (SEL_W)
  ) u_dec (
    .addr_i(addr_d),
    .sel_c (dec_sel_c)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    down_d  = down_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = RUN;
          addr_d  = cmd_start;
          rem_d   = cmd_len;
          down_d  = cmd_down;
        end
      end
      RUN: begin
        if (xfer_c) begin
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d = down_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            rem_d  = rem_q - ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d     = (state_d == RUN);
    busy_d      = (state_d == RUN);
    cmd_ready_d = (state_d == IDLE);
    last_d      = (state_d == RUN) && (rem_d == '0);
    sel_d       = (state_d == RUN) ? dec_sel_c : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      down_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      down_q      <= down_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      sel_q       <= sel_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
endmodule
